// File: rtl/apb_pkg.sv
// Shared APB types and default bus widths for the APB master and the register slaves.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_t;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_master_arb_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr wins, one-hot grant.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt
);

  logic found;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// APB master sharing one slave port between NUM_REQ requesters with round-robin arbitration.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("apb_master_arb: NUM_REQ must be 2..4 and TIMEOUT >= 1");
  end

  apb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [IDX_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // A requester whose completion pulse is still high is masked, so its held req_valid
  // cannot win a second grant on the same request.
  rr_arbiter #(.N(NUM_REQ), .PTR_W(IDX_W)) u_arb (
    .req (req_valid & ~req_done_q),
    .ptr (rr_ptr_q),
    .en  (state_q == APB_IDLE),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = IDX_W'(i);
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    req_done_d  = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      APB_IDLE: begin
        if (|gnt) begin
          state_d  = APB_SETUP;
          idx_d    = gnt_idx;
          psel_d   = 1'b1;
          paddr_d  = sel_addr;
          pwrite_d = sel_write;
          pwdata_d = sel_write ? sel_wdata : '0;
          rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
      end

      APB_SETUP: begin
        state_d   = APB_ACCESS;
        penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end

      APB_ACCESS: begin
        if (pready) begin
          state_d            = APB_IDLE;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          req_done_d[idx_q]  = 1'b1;
          rsp_rdata_d        = pwrite_q ? '0 : prdata;
          rsp_err_d          = pslverr;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // Counter value TIMEOUT-1 means this edge closes the TIMEOUT-th ACCESS cycle.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d            = APB_IDLE;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
          req_done_d[idx_q]  = 1'b1;
          rsp_rdata_d        = '0;
          rsp_err_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      default: state_d = APB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= APB_IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_done_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_done_q  <= req_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  assign req_done  = req_done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != APB_IDLE);
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule
